// File: rtl/des_ctrl_pkg.sv
// Shared definitions for the DES/LFSR Feistel datapath control.
package des_ctrl_pkg;

  localparam int NUM_ROUNDS_DEF = 16;
  localparam int ROUND_W_DEF    = 4;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARM   = 3'd2,
    ST_ROUND = 3'd3,
    ST_FINAL = 3'd4,
    ST_OUT   = 3'd5
  } state_e;

endpackage

// File: rtl/des_round_counter.sv
// Round index counter: presettable, counts up or down, and stops at the terminal index.
module des_round_counter #(
  parameter int ROUND_W    = 4,
  parameter int NUM_ROUNDS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               preset_i,
  input  logic [ROUND_W-1:0] preset_val_i,
  input  logic               en_i,
  input  logic               down_i,
  output logic [ROUND_W-1:0] cnt_o,
  output logic               tc_o
);

  localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NUM_ROUNDS - 1);

  logic [ROUND_W-1:0] cnt_q, cnt_d;

  // Terminal index: last round for up-counting, round 0 for down-counting.
  assign tc_o  = down_i ? (cnt_q == '0) : (cnt_q == LAST);
  assign cnt_o = cnt_q;

  // Next count; the terminal index is held so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (preset_i) begin
      cnt_d = preset_val_i;
    end else if (en_i && !tc_o) begin
      cnt_d = down_i ? (cnt_q - ROUND_W'(1)) : (cnt_q + ROUND_W'(1));
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for one DES block: load, arm, NUM_ROUNDS Feistel rounds, final swap, result handshake.
module des_round_ctrl
  import des_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS  = NUM_ROUNDS_DEF,
  parameter int ROUND_W     = ROUND_W_DEF,
  parameter int ARM_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode_in,
  output logic               load,
  input  logic               trigger_in,
  output logic               key_load,
  output logic               key_step,
  output logic               round_en,
  output logic [ROUND_W-1:0] round_idx,
  output logic               mode_q,
  output logic               final_swap,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err
);

  localparam int                 ARM_W    = $clog2(ARM_TIMEOUT + 1);
  localparam logic [ARM_W-1:0]   ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);
  localparam logic [ROUND_W-1:0] RND_LAST = ROUND_W'(NUM_ROUNDS - 1);

  state_e             state_q, state_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic               mode_lat_q;
  logic               in_ready_q, busy_q, err_q, err_d;
  logic               rnd_preset, rnd_tc, rnd_down;
  logic [ROUND_W-1:0] rnd_preset_val;

  // The round index starts counting on the cycle the trigger moves us into ROUND,
  // so it keeps its previous value while waiting in ARM.
  assign rnd_down       = (mode_lat_q == MODE_DEC);
  assign rnd_preset     = (state_q == ST_ARM) && trigger_in;
  assign rnd_preset_val = rnd_down ? RND_LAST : '0;

  des_round_counter #(
    .ROUND_W   (ROUND_W),
    .NUM_ROUNDS(NUM_ROUNDS)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .preset_i    (rnd_preset),
    .preset_val_i(rnd_preset_val),
    .en_i        (state_q == ST_ROUND),
    .down_i      (rnd_down),
    .cnt_o       (round_idx),
    .tc_o        (rnd_tc)
  );

  // Next-state decode, arm timeout tracking and error pulse generation.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE:  if (in_valid && in_ready_q) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d   = ST_ARM;
        arm_cnt_d = '0;
      end
      ST_ARM: begin
        if (trigger_in) begin
          state_d = ST_ROUND;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end
      ST_ROUND: if (rnd_tc) state_d = ST_FINAL;
      ST_FINAL: state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register plus registered handshake/status outputs, which track the next state
  // so in_ready only rises on the cycle after the output handshake completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      arm_cnt_q  <= '0;
      mode_lat_q <= MODE_ENC;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      in_ready_q <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      err_q      <= err_d;
      if (state_q == ST_IDLE && in_valid && in_ready_q) begin
        mode_lat_q <= mode_in;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign mode_q     = mode_lat_q;
  assign load       = (state_q == ST_LOAD);
  assign key_load   = (state_q == ST_LOAD);
  assign key_step   = (state_q == ST_ROUND);
  assign round_en   = (state_q == ST_ROUND);
  assign final_swap = (state_q == ST_FINAL);
  assign out_valid  = (state_q == ST_OUT);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl.
module tb_des_round_ctrl;

  localparam int NR = 16;
  localparam int RW = 4;
  localparam int AT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          mode_in = 1'b0;
  logic          trigger_in = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready, load, key_load, key_step, round_en, mode_q;
  logic          final_swap, out_valid, busy, err;
  logic [RW-1:0] round_idx;

  int tests = 0;
  int fails = 0;
  int load_cnt = 0;
  int hs_cnt = 0;

  des_round_ctrl #(
    .NUM_ROUNDS (NR),
    .ROUND_W    (RW),
    .ARM_TIMEOUT(AT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode_in   (mode_in),
    .load      (load),
    .trigger_in(trigger_in),
    .key_load  (key_load),
    .key_step  (key_step),
    .round_en  (round_en),
    .round_idx (round_idx),
    .mode_q    (mode_q),
    .final_swap(final_swap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load === 1'b1) load_cnt <= load_cnt + 1;
    if (out_valid === 1'b1 && out_ready === 1'b1) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full block; bp = cycles of out_ready low in OUT, tog = wiggle in_valid/mode_in while busy.
  task automatic run_block(input logic m, input int bp, input bit tog);
    int lc0;
    int hs0;
    int exp_idx;
    lc0 = load_cnt;
    hs0 = hs_cnt;
    out_ready = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    mode_in  = m;
    cyc();  // T+1
    chk("load_T1", load, 1);
    chk("key_load_T1", key_load, 1);
    chk("busy_T1", busy, 1);
    chk("in_ready_T1", in_ready, 0);
    chk("mode_q_T1", mode_q, m);
    in_valid = tog;
    mode_in  = ~m;
    cyc();  // T+2
    chk("load_T2", load, 0);
    chk("round_en_T2", round_en, 0);
    trigger_in = 1'b1;
    cyc();  // T+3
    trigger_in = 1'b0;
    for (int i = 0; i < NR; i++) begin
      exp_idx = m ? (NR - 1 - i) : i;
      chk("round_en", round_en, 1);
      chk("key_step", key_step, 1);
      chk("round_idx", round_idx, exp_idx);
      chk("mode_q_round", mode_q, m);
      if (tog) begin
        in_valid = i[0];
        mode_in  = i[1];
      end
      cyc();
    end
    // T+19
    chk("final_swap", final_swap, 1);
    chk("round_en_final", round_en, 0);
    chk("out_valid_final", out_valid, 0);
    if (bp > 0) out_ready = 1'b0;
    cyc();  // T+20
    for (int b = 0; b < bp; b++) begin
      chk("out_valid_bp", out_valid, 1);
      chk("in_ready_bp", in_ready, 0);
      cyc();
    end
    out_ready = 1'b1;
    chk("out_valid", out_valid, 1);
    chk("in_ready_out", in_ready, 0);
    chk("final_swap_out", final_swap, 0);
    cyc();  // handshake done
    in_valid = 1'b0;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
    chk("mode_q_after", mode_q, m);
    chk("load_pulses", load_cnt - lc0, 1);
    chk("out_handshakes", hs_cnt - hs0, 1);
  endtask

  initial begin
    int lc0;
    int hs0;

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    chk("rst_round_en", round_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_mode_q", mode_q, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Encrypt, decrypt, then backpressure
    run_block(1'b0, 0, 1'b0);
    run_block(1'b1, 0, 1'b0);
    run_block(1'b0, 5, 1'b0);

    // Arm timeout: no trigger
    lc0 = load_cnt;
    chk("to_in_ready", in_ready, 1);
    in_valid = 1'b1;
    mode_in  = 1'b0;
    cyc();  // T+1
    in_valid = 1'b0;
    chk("to_load", load, 1);
    cyc();  // T+2
    for (int k = 0; k < AT; k++) begin
      chk("to_err_wait", err, 0);
      chk("to_busy_wait", busy, 1);
      chk("to_round_en", round_en, 0);
      cyc();
    end
    // T+6
    chk("to_err", err, 1);
    chk("to_in_ready_back", in_ready, 1);
    chk("to_busy_back", busy, 0);
    chk("to_round_en_end", round_en, 0);
    cyc();
    chk("to_err_pulse", err, 0);
    chk("to_load_pulses", load_cnt - lc0, 1);

    // Reset during round 7
    hs0 = hs_cnt;
    in_valid = 1'b1;
    mode_in  = 1'b0;
    cyc();  // T+1
    in_valid = 1'b0;
    cyc();  // T+2
    trigger_in = 1'b1;
    cyc();  // T+3
    trigger_in = 1'b0;
    repeat (7) cyc();
    chk("mid_round_idx", round_idx, 7);
    rst = 1'b1;
    cyc();
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_round_en", round_en, 0);
    chk("mrst_key_step", key_step, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_final_swap", final_swap, 0);
    chk("mrst_err", err, 0);
    chk("mrst_round_idx", round_idx, 0);
    rst = 1'b0;
    cyc();
    chk("mrst_in_ready_back", in_ready, 1);
    chk("mrst_no_output", hs_cnt - hs0, 0);
    chk("mrst_err_after", err, 0);
    run_block(1'b0, 0, 1'b0);

    // in_valid / mode_in wiggled while busy, two blocks back to back
    run_block(1'b1, 0, 1'b1);
    run_block(1'b0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
